// File: rtl/red_region_detector_if.sv
// Valid/ready pixel stream with start/end-of-frame markers.
// A producer connects through the master modport and a consumer through the slave modport.
interface red_region_detector_if;
  logic [11:0] data;
  logic        valid;
  logic        sop;
  logic        eop;
  logic        ready;

  modport master (
    output data,
    output valid,
    output sop,
    output eop,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  sop,
    input  eop,
    output ready
  );
endinterface

// File: rtl/red_region_detector.sv
// Red region detector: classifies RGB444 pixels as red, streams a binary mask
// through a one-register pipeline stage, and gathers per-frame red statistics
// (total and left/centre/right thirds) plus a steering direction.
module red_region_detector #(
  parameter int          IMG_WIDTH  = 320,
  parameter int          IMG_HEIGHT = 240,
  parameter logic [3:0]  R_MIN      = 4'd10,
  parameter logic [16:0] MIN_PIXELS = 17'd200
) (
  input  logic                         clk_25_vga,
  input  logic                         reset,
  red_region_detector_if.slave         in_st,
  red_region_detector_if.master        out_st,
  input  logic [3:0]                   upper_thresh,
  output logic [16:0]                  red_pixels,
  output logic [16:0]                  red_left,
  output logic [16:0]                  red_centre,
  output logic [16:0]                  red_right,
  output logic [1:0]                   direction,
  output logic                         frame_done
);

  // Column counter only needs to reach IMG_WIDTH-1.
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  // Running counters are as wide as a whole frame needs, capped at the
  // 17-bit statistics width; they stick at their all-ones value.
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int FRAME_BITS   = $clog2(FRAME_PIXELS + 1);
  localparam int CNT_W        = (FRAME_BITS < 17) ? ((FRAME_BITS < 1) ? 1 : FRAME_BITS) : 17;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] BOUND_1  = COL_W'(IMG_WIDTH / 3);
  localparam logic [COL_W-1:0] BOUND_2  = COL_W'((2 * IMG_WIDTH) / 3);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Stream stage
  // ---------------------------------------------------------------------------
  logic [11:0] data_reg;
  logic        valid_reg;
  logic        sop_reg;
  logic        eop_reg;
  logic        ready;
  logic        in_xfer;
  logic        is_red;

  // The stage accepts when the output register is empty or draining this cycle.
  assign ready       = out_st.ready | ~valid_reg;
  assign in_st.ready = ready;
  assign in_xfer     = in_st.valid & ready;

  assign is_red = (in_st.data[11:8] >= R_MIN) &
                  (in_st.data[7:4]  <  upper_thresh) &
                  (in_st.data[3:0]  <  upper_thresh);

  assign out_st.data  = data_reg;
  assign out_st.valid = valid_reg;
  assign out_st.sop   = sop_reg;
  assign out_st.eop   = eop_reg;

  // Output register: load on input transfer, empty when drained with nothing new, hold when stalled.
  always_ff @(posedge clk_25_vga or posedge reset) begin
    if (reset) begin
      data_reg  <= 12'h000;
      valid_reg <= 1'b0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
    end else if (in_xfer) begin
      data_reg  <= is_red ? 12'hFFF : 12'h000;
      valid_reg <= 1'b1;
      sop_reg   <= in_st.sop;
      eop_reg   <= in_st.eop;
    end else if (out_st.ready) begin
      valid_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   frame_start;  // sop transfer: counters restart with this pixel
  logic   counted;      // this transfer contributes to the running counts
  logic   frame_end;    // eop transfer of a counted frame: latch statistics

  // State register.
  always_ff @(posedge clk_25_vga or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and frame event decode; an sop in either state (re)starts a frame.
  always_comb begin
    frame_start = in_xfer & in_st.sop;
    counted     = in_xfer & (in_st.sop | (state == COUNT));
    frame_end   = counted & in_st.eop;
    state_next  = state;
    if (frame_end) begin
      state_next = IDLE;
    end else if (counted) begin
      state_next = COUNT;
    end
  end

  // ---------------------------------------------------------------------------
  // Column tracking
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_cur;   // column of the pixel being transferred
  logic [COL_W-1:0] col_next;
  logic [3:0]       hit;       // [0] whole frame, [1] left, [2] centre, [3] right

  // Current column, its successor and which third it lies in.
  always_comb begin
    col_cur  = frame_start ? '0 : col;
    col_next = (col_cur == LAST_COL) ? '0 : col_cur + COL_W'(1);
    hit[0]   = 1'b1;
    hit[1]   = (col_cur < BOUND_1);
    hit[2]   = (col_cur >= BOUND_1) & (col_cur < BOUND_2);
    hit[3]   = (col_cur >= BOUND_2);
  end

  // Column advances on every counted transfer and restarts at each frame end.
  always_ff @(posedge clk_25_vga or posedge reset) begin
    if (reset) begin
      col <= '0;
    end else if (frame_end) begin
      col <= '0;
    end else if (counted) begin
      col <= col_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Running counters and latched statistics (total, left, centre, right)
  // ---------------------------------------------------------------------------
  logic [3:0][CNT_W-1:0] sum_final;  // counts including the current pixel
  logic [3:0][CNT_W-1:0] stat_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] stat_reg;
      logic [CNT_W-1:0] base;

      assign base          = frame_start ? '0 : cnt_reg;
      assign sum_final[gi] = (is_red & hit[gi] & (base != CNT_MAX)) ? base + CNT_W'(1) : base;
      assign stat_vec[gi]  = stat_reg;

      // Running count: restart on sop, clear after the frame closes, else accumulate.
      always_ff @(posedge clk_25_vga or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (frame_end) begin
          cnt_reg <= '0;
        end else if (counted) begin
          cnt_reg <= sum_final[gi];
        end
      end

      // Statistics snapshot of the last completed frame, eop pixel included.
      always_ff @(posedge clk_25_vga or posedge reset) begin
        if (reset) begin
          stat_reg <= '0;
        end else if (frame_end) begin
          stat_reg <= sum_final[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Direction and frame_done
  // ---------------------------------------------------------------------------
  logic [16:0] fin_total;
  logic [16:0] fin_left;
  logic [16:0] fin_centre;
  logic [16:0] fin_right;
  logic [1:0]  dir_final;
  logic [1:0]  direction_reg;
  logic        frame_done_reg;

  // Steering from the final totals: none if too few, else largest third (centre, then left on ties).
  always_comb begin
    fin_total  = 17'(sum_final[0]);
    fin_left   = 17'(sum_final[1]);
    fin_centre = 17'(sum_final[2]);
    fin_right  = 17'(sum_final[3]);
    dir_final  = 2'b00;
    if (fin_total >= MIN_PIXELS) begin
      if ((fin_centre >= fin_left) && (fin_centre >= fin_right)) begin
        dir_final = 2'b10;
      end else if (fin_left >= fin_right) begin
        dir_final = 2'b01;
      end else begin
        dir_final = 2'b11;
      end
    end
  end

  // Direction latches alongside the statistics; frame_done pulses for that one cycle.
  always_ff @(posedge clk_25_vga or posedge reset) begin
    if (reset) begin
      direction_reg  <= 2'b00;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      if (frame_end) begin
        direction_reg <= dir_final;
      end
    end
  end

  assign red_pixels = 17'(stat_vec[0]);
  assign red_left   = 17'(stat_vec[1]);
  assign red_centre = 17'(stat_vec[2]);
  assign red_right  = 17'(stat_vec[3]);
  assign direction  = direction_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_red_region_detector.sv
// Directed bench for red_region_detector on a reduced 30x16 image:
// mask stream checked through a scoreboard, statistics against a pixel model.
module tb_red_region_detector;

  localparam int          W    = 30;
  localparam int          H    = 16;
  localparam logic [16:0] MINP = 17'd40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ut  = 4'h8;
  logic [16:0] rp, rl, rc, rr;
  logic [1:0]  dir;
  logic        fd;

  always #5 clk = ~clk;

  red_region_detector_if in_st ();
  red_region_detector_if out_st ();

  red_region_detector #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .R_MIN      (4'd10),
    .MIN_PIXELS (MINP)
  ) dut (
    .clk_25_vga   (clk),
    .reset        (rst),
    .in_st        (in_st),
    .out_st       (out_st),
    .upper_thresh (ut),
    .red_pixels   (rp),
    .red_left     (rl),
    .red_centre   (rc),
    .red_right    (rr),
    .direction    (dir),
    .frame_done   (fd)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [11:0] data;
  } beat_t;

  beat_t sb_q[$];
  beat_t exp_beat;
  int    compared   = 0;
  int    mismatched = 0;
  int    fd_count   = 0;
  int    exp_tot, exp_l, exp_c, exp_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic bit ref_red(input logic [11:0] p, input logic [3:0] t);
    return (p[11:8] >= 4'd10) && (p[7:4] < t) && (p[3:0] < t);
  endfunction

  function automatic logic [1:0] ref_dir(input int t, input int l, input int c, input int r);
    if (t < int'(MINP)) return 2'b00;
    if (c >= l && c >= r) return 2'b10;
    if (l >= r) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [11:0] pattern(input int kind, input int line, input int col);
    case (kind)
      1: return 12'hF00;
      2: return (col < 5) ? 12'hE11 : 12'h888;
      3: return ((line == 0 && col >= 20) || (line == 1 && col >= 20 && col < 25)) ? 12'hF00 : 12'h0F0;
      4: return (col >= 20) ? 12'hD22 : 12'h333;
      5: return (col == 9 || col == 10 || col == 19 || col == 20) ? 12'hF00 : 12'h000;
      6: begin
        if (col % 3 == 0) return 12'hA70;
        else if (col % 3 == 1) return 12'hA80;
        else return 12'h907;
      end
      7: return (col < 10 || col >= 20) ? 12'hF00 : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  // Scoreboard: pop/compare on output transfers, push expected beats on input transfers.
  always @(negedge clk) begin
    if (!rst) begin
      if (fd) fd_count++;
      if (out_st.valid && out_st.ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_beat = sb_q.pop_front();
          check("out_beat", {18'd0, out_st.sop, out_st.eop, out_st.data}, {18'd0, exp_beat});
        end
      end
      if (in_st.valid && in_st.ready) begin
        sb_q.push_back({in_st.sop, in_st.eop, ref_red(in_st.data, ut) ? 12'hFFF : 12'h000});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Present one pixel and hold it until accepted; returns 1 time unit after the transfer edge.
  task automatic send(input logic [11:0] d, input logic s, input logic e);
    int guard;
    guard = 0;
    in_st.data  = d;
    in_st.valid = 1'b1;
    in_st.sop   = s;
    in_st.eop   = e;
    @(negedge clk);
    while (!in_st.ready) begin
      guard++;
      if (guard > 100) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_st.valid = 1'b0;
    in_st.sop   = 1'b0;
    in_st.eop   = 1'b0;
  endtask

  // Hold out_ready low for five cycles with a pixel pending and check that the stage holds.
  task automatic stall5(input logic [11:0] p);
    logic [31:0] held;
    out_st.ready = 1'b0;
    in_st.data   = p;
    in_st.valid  = 1'b1;
    in_st.sop    = 1'b0;
    in_st.eop    = 1'b0;
    @(negedge clk);
    held = {18'd0, out_st.sop, out_st.eop, out_st.data};
    check("stall_out_valid", {31'd0, out_st.valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_st.ready}, 32'd0);
      check("stall_out_hold", {18'd0, out_st.sop, out_st.eop, out_st.data}, held);
    end
    @(posedge clk);
    #1;
    out_st.ready = 1'b1;
  endtask

  // Stream npix pixels of a pattern, updating the statistics model.
  task automatic send_frame(input int kind, input int npix, input bit do_sop, input bit do_eop, input int stall_at);
    int line, col;
    logic [11:0] p;
    if (do_sop) begin
      exp_tot = 0; exp_l = 0; exp_c = 0; exp_r = 0;
    end
    for (int i = 0; i < npix; i++) begin
      line = i / W;
      col  = i % W;
      p    = pattern(kind, line, col);
      if (ref_red(p, ut)) begin
        exp_tot++;
        if (col < W / 3) exp_l++;
        else if (col < (2 * W) / 3) exp_c++;
        else exp_r++;
      end
      if (i == stall_at) stall5(p);
      send(p, do_sop && (i == 0), do_eop && (i == npix - 1));
    end
  endtask

  // Called right after the eop transfer: statistics and a one-cycle frame_done.
  task automatic frame_end_check(input string tag);
    int fd_before;
    fd_before = fd_count;
    @(negedge clk);
    check({tag, "_frame_done"}, {31'd0, fd}, 32'd1);
    check({tag, "_red_pixels"}, {15'd0, rp}, exp_tot);
    check({tag, "_red_left"}, {15'd0, rl}, exp_l);
    check({tag, "_red_centre"}, {15'd0, rc}, exp_c);
    check({tag, "_red_right"}, {15'd0, rr}, exp_r);
    check({tag, "_direction"}, {30'd0, dir}, {30'd0, ref_dir(exp_tot, exp_l, exp_c, exp_r)});
    @(negedge clk);
    check({tag, "_frame_done_end"}, {31'd0, fd}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse_count"}, fd_count - fd_before, 32'd1);
  endtask

  initial begin
    int fd_snap;
    int prev_tot, prev_l;
    in_st.data   = 12'h000;
    in_st.valid  = 1'b0;
    in_st.sop    = 1'b0;
    in_st.eop    = 1'b0;
    out_st.ready = 1'b1;

    // Reset state
    #23;
    check("rst_out_valid", {31'd0, out_st.valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_st.ready}, 32'd1);
    check("rst_red_pixels", {15'd0, rp}, 32'd0);
    check("rst_direction", {30'd0, dir}, 32'd0);
    check("rst_frame_done", {31'd0, fd}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: all-red frame, equal thirds -> centre
    send_frame(1, W * H, 1, 1, -1);
    frame_end_check("t1_all_red");

    // 2: red in columns 0..4 only -> left
    send_frame(2, W * H, 1, 1, -1);
    frame_end_check("t2_left");

    // 3: 15 red pixels in the right third -> below threshold
    send_frame(3, W * H, 1, 1, -1);
    frame_end_check("t3_sparse_right");

    // right-third frame with a lower per-pixel threshold -> right
    ut = 4'h3;
    send_frame(4, W * H, 1, 1, -1);
    frame_end_check("t_right");
    ut = 4'h8;

    // third boundaries on columns 9/10 and 19/20
    send_frame(5, W * H, 1, 1, -1);
    frame_end_check("t_bounds");

    // left/right tie -> left
    send_frame(7, W * H, 1, 1, -1);
    frame_end_check("t_tie_lr");

    // R/G/B compare boundaries, unstalled reference
    send_frame(6, W * H, 1, 1, -1);
    frame_end_check("t_nibble_edges");

    // 4: same frame with a five-cycle output stall mid-frame
    send_frame(6, W * H, 1, 1, 200);
    frame_end_check("t4_stall");

    // single-pixel frame (sop and eop together)
    send_frame(1, 1, 1, 1, -1);
    frame_end_check("t_single");

    // 5: truncated segment then a new sop and full frame
    prev_tot = exp_tot;
    prev_l   = exp_l;
    fd_snap  = fd_count;
    send_frame(1, 100, 1, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done_truncated", fd_count - fd_snap, 32'd0);
    check("t5_hold_red_pixels", {15'd0, rp}, prev_tot);
    check("t5_hold_red_left", {15'd0, rl}, prev_l);
    send_frame(2, W * H, 1, 1, -1);
    frame_end_check("t5_second_frame");

    // 6: asynchronous reset mid-frame, then eop without sop
    send_frame(1, 50, 1, 0, -1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_red_pixels", {15'd0, rp}, 32'd0);
    check("t6_rst_red_left", {15'd0, rl}, 32'd0);
    check("t6_rst_direction", {30'd0, dir}, 32'd0);
    check("t6_rst_out_valid", {31'd0, out_st.valid}, 32'd0);
    check("t6_rst_in_ready", {31'd0, in_st.ready}, 32'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fd_snap = fd_count;
    send_frame(1, 20, 0, 1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_eop_no_done", fd_count - fd_snap, 32'd0);
    check("t6_idle_red_pixels", {15'd0, rp}, 32'd0);

    // drain
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
